// File: rtl/decode_issue_stage_pkg.sv
// Shared types and constants for the decode/issue stage: field positions, opcode map, decoded bundle.
// Latency: n/a (types and a combinational classify helper only).
// Backpressure: n/a.
package decode_issue_stage_pkg;

    localparam int THR_PER_CORE = 2;
    localparam int NUM_REGS     = 32;
    localparam int REG_WIDTH    = 32;
    localparam int INSTR_WIDTH  = 32;
    localparam int PC_WIDTH     = 32;
    localparam int THR_ID_W     = $clog2(THR_PER_CORE);
    localparam int REG_ID_W     = $clog2(NUM_REGS);

    // Source slots queried per instruction: rs1, rs2 and rd (store data)
    localparam int SRC_CNT  = 3;
    localparam int SRC_RS1  = 0;
    localparam int SRC_RS2  = 1;
    localparam int SRC_RD   = 2;

    // Instruction field positions
    localparam int OPC_HI = 31;
    localparam int OPC_LO = 25;
    localparam int RD_HI  = 24;
    localparam int RD_LO  = 20;
    localparam int RS1_HI = 19;
    localparam int RS1_LO = 15;
    localparam int RS2_HI = 14;
    localparam int RS2_LO = 10;
    localparam int IMM_HI = 14;
    localparam int IMM_LO = 0;
    localparam int OPC_W  = OPC_HI - OPC_LO + 1;

    // Opcode map (ALU starts at zero, so only its upper bound is needed)
    localparam logic [OPC_W-1:0] OPC_ALU_HI = 7'h0F;
    localparam logic [OPC_W-1:0] OPC_LD_LO  = 7'h10;
    localparam logic [OPC_W-1:0] OPC_LD_HI  = 7'h11;
    localparam logic [OPC_W-1:0] OPC_ST_LO  = 7'h12;
    localparam logic [OPC_W-1:0] OPC_ST_HI  = 7'h13;
    localparam logic [OPC_W-1:0] OPC_BR_LO  = 7'h30;
    localparam logic [OPC_W-1:0] OPC_BR_HI  = 7'h31;

    typedef enum logic [2:0] {
        CLS_ALU = 3'd0,
        CLS_LD  = 3'd1,
        CLS_ST  = 3'd2,
        CLS_BR  = 3'd3,
        CLS_ILL = 3'd4
    } instr_class_t;

    typedef struct packed {
        logic misaligned;
        logic access_fault;
    } fetch_xcpt_t;

    // For stores, rs2_val carries the store data read from rd
    typedef struct packed {
        logic [OPC_W-1:0]     opcode;
        instr_class_t         cls;
        logic [THR_ID_W-1:0]  thread;
        logic [PC_WIDTH-1:0]  pc;
        logic [REG_ID_W-1:0]  rd;
        logic [REG_WIDTH-1:0] rs1_val;
        logic [REG_WIDTH-1:0] rs2_val;
        logic [REG_WIDTH-1:0] imm;
        fetch_xcpt_t          xcpt;
        logic                 xcpt_illegal;
    } decode_info_t;

    function automatic instr_class_t classify(input logic [OPC_W-1:0] opc);
        instr_class_t cls;
        if (opc <= OPC_ALU_HI)                         cls = CLS_ALU;
        else if (opc >= OPC_LD_LO && opc <= OPC_LD_HI) cls = CLS_LD;
        else if (opc >= OPC_ST_LO && opc <= OPC_ST_HI) cls = CLS_ST;
        else if (opc >= OPC_BR_LO && opc <= OPC_BR_HI) cls = CLS_BR;
        else                                           cls = CLS_ILL;
        return cls;
    endfunction

endpackage

// File: rtl/decode_issue_stage_if.sv
// Fetch, flush, write-back and issue signals of the decode/issue stage bundled as one port.
// Latency: n/a (wiring only).
// Backpressure: stall_fetch per thread toward fetch; alu_stall from the ALU.
interface decode_issue_stage_if;
    import decode_issue_stage_pkg::*;

    logic                    fetch_valid;
    logic [INSTR_WIDTH-1:0]  fetch_instr;
    logic [PC_WIDTH-1:0]     fetch_pc;
    logic [THR_ID_W-1:0]     fetch_thread_id;
    fetch_xcpt_t             fetch_xcpt;
    logic [THR_PER_CORE-1:0] stall_fetch;
    logic [THR_PER_CORE-1:0] flush;
    logic                    alu_stall;
    logic                    wb_valid;
    logic [THR_ID_W-1:0]     wb_thread_id;
    logic [REG_ID_W-1:0]     wb_reg;
    logic [REG_WIDTH-1:0]    wb_data;
    logic                    issue_valid;
    decode_info_t            issue_info;

    // Surrounding pipeline side
    modport master (
        output fetch_valid, fetch_instr, fetch_pc, fetch_thread_id, fetch_xcpt,
        output flush, alu_stall, wb_valid, wb_thread_id, wb_reg, wb_data,
        input  stall_fetch, issue_valid, issue_info
    );

    // Decode/issue stage side
    modport slave (
        input  fetch_valid, fetch_instr, fetch_pc, fetch_thread_id, fetch_xcpt,
        input  flush, alu_stall, wb_valid, wb_thread_id, wb_reg, wb_data,
        output stall_fetch, issue_valid, issue_info
    );

endinterface

// File: rtl/decode_issue_stage_reg_scoreboard.sv
// Per-thread pending-write bits with one set and one clear port; set wins on a same-bit collision.
// Latency: set/clear take effect at the next edge; the pending query is combinational.
// Backpressure: none; a same-cycle clear already masks the query so the consumer can issue in the wb cycle.
module decode_issue_stage_reg_scoreboard
    import decode_issue_stage_pkg::*;
(
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               set_vld,
    input  logic [THR_ID_W-1:0]                set_thread,
    input  logic [REG_ID_W-1:0]                set_reg,
    input  logic                               clr_vld,
    input  logic [THR_ID_W-1:0]                clr_thread,
    input  logic [REG_ID_W-1:0]                clr_reg,
    input  logic [THR_ID_W-1:0]                query_thread,
    input  logic [SRC_CNT-1:0][REG_ID_W-1:0]   query_reg,
    output logic [SRC_CNT-1:0]                 pending
);

    logic [THR_PER_CORE-1:0][NUM_REGS-1:0] pend_q;
    logic [THR_PER_CORE-1:0][NUM_REGS-1:0] pend_d;

    // Next pending state: clear first so a colliding set overrides it; r0 can never be pending
    always_comb begin
        pend_d = pend_q;
        if (clr_vld) pend_d[clr_thread][clr_reg] = 1'b0;
        if (set_vld) pend_d[set_thread][set_reg] = 1'b1;
        for (int t = 0; t < THR_PER_CORE; t++) pend_d[t][0] = 1'b0;
    end

    // Pending bit register
    always_ff @(posedge clock) begin
        if (reset) pend_q <= '0;
        else       pend_q <= pend_d;
    end

    // A source is blocking only if it is pending and not being written back this cycle
    always_comb begin
        for (int i = 0; i < SRC_CNT; i++) begin
            pending[i] = pend_q[query_thread][query_reg[i]] &&
                         !(clr_vld && clr_thread == query_thread && clr_reg == query_reg[i]);
        end
    end

endmodule

// File: rtl/decode_issue_stage.sv
// Decode/issue: one-entry hold register, per-thread regfile + scoreboard, one issue per cycle to the ALU.
// Latency: fetch accepted in cycle N issues in N+1 absent hazards; issue outputs are decoded from the held entry.
// Backpressure: RAW hazard or alu_stall holds the entry and raises stall_fetch only for the owning thread.
module decode_issue_stage
    import decode_issue_stage_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    decode_issue_stage_if.slave  io
);

    // Hold entry
    logic                   ent_vld;
    logic [INSTR_WIDTH-1:0] ent_instr;
    logic [PC_WIDTH-1:0]    ent_pc;
    logic [THR_ID_W-1:0]    ent_thread;
    fetch_xcpt_t            ent_xcpt;

    // Register file, one bank per thread; r0 is never written so it always reads zero
    logic [THR_PER_CORE-1:0][NUM_REGS-1:0][REG_WIDTH-1:0] rf_q;

    // Decode of the held entry
    logic [OPC_W-1:0]    opc;
    logic [REG_ID_W-1:0] rd;
    instr_class_t        cls;
    logic                no_effect;
    logic                writes_rd;

    logic [SRC_CNT-1:0][REG_ID_W-1:0]  src_reg;
    logic [SRC_CNT-1:0]                src_use;
    logic [SRC_CNT-1:0]                src_pend;
    logic [SRC_CNT-1:0][REG_WIDTH-1:0] src_val;

    logic hazard;
    logic flush_ent;
    logic issue_fire;
    logic leaving;
    logic capture;

    // Field extraction and per-class source/destination usage
    always_comb begin
        opc       = ent_instr[OPC_HI:OPC_LO];
        rd        = ent_instr[RD_HI:RD_LO];
        cls       = classify(opc);
        // Faulting and illegal instructions flow through as no-ops: no reads, no hazard, no scoreboard set
        no_effect = (|ent_xcpt) || (cls == CLS_ILL);

        src_reg[SRC_RS1] = ent_instr[RS1_HI:RS1_LO];
        src_reg[SRC_RS2] = ent_instr[RS2_HI:RS2_LO];
        src_reg[SRC_RD]  = rd;

        src_use[SRC_RS1] = !no_effect;
        src_use[SRC_RS2] = !no_effect && (cls == CLS_ALU || cls == CLS_BR);
        src_use[SRC_RD]  = !no_effect && (cls == CLS_ST);

        writes_rd = !no_effect && (cls == CLS_ALU || cls == CLS_LD) && (rd != '0);
    end

    // Register read with same-cycle write-back forwarding
    always_comb begin
        for (int i = 0; i < SRC_CNT; i++) begin
            src_val[i] = rf_q[ent_thread][src_reg[i]];
            if (io.wb_valid && io.wb_thread_id == ent_thread &&
                io.wb_reg == src_reg[i] && src_reg[i] != '0) begin
                src_val[i] = io.wb_data;
            end
        end
    end

    decode_issue_stage_reg_scoreboard u_sb (
        .clock        (clock),
        .reset        (reset),
        .set_vld      (issue_fire && writes_rd),
        .set_thread   (ent_thread),
        .set_reg      (rd),
        .clr_vld      (io.wb_valid),
        .clr_thread   (io.wb_thread_id),
        .clr_reg      (io.wb_reg),
        .query_thread (ent_thread),
        .query_reg    (src_reg),
        .pending      (src_pend)
    );

    // Issue / capture handshake; a flushed entry leaves without issuing
    always_comb begin
        hazard     = |(src_use & src_pend);
        flush_ent  = io.flush[ent_thread];
        issue_fire = ent_vld && !io.alu_stall && !hazard && !flush_ent;
        leaving    = issue_fire || (ent_vld && flush_ent);
        capture    = io.fetch_valid && !io.flush[io.fetch_thread_id] && (!ent_vld || leaving);
    end

    // Hold entry register
    always_ff @(posedge clock) begin
        if (reset) begin
            ent_vld    <= 1'b0;
            ent_instr  <= '0;
            ent_pc     <= '0;
            ent_thread <= '0;
            ent_xcpt   <= '0;
        end else if (capture) begin
            ent_vld    <= 1'b1;
            ent_instr  <= io.fetch_instr;
            ent_pc     <= io.fetch_pc;
            ent_thread <= io.fetch_thread_id;
            ent_xcpt   <= io.fetch_xcpt;
        end else if (leaving) begin
            ent_vld    <= 1'b0;
        end
    end

    // Register file write-back; writes to r0 are dropped
    always_ff @(posedge clock) begin
        if (reset) begin
            rf_q <= '0;
        end else if (io.wb_valid && io.wb_reg != '0) begin
            rf_q[io.wb_thread_id][io.wb_reg] <= io.wb_data;
        end
    end

    // Per-thread stall: only the thread owning a stuck entry is held
    always_comb begin
        io.stall_fetch = '0;
        for (int t = 0; t < THR_PER_CORE; t++) begin
            io.stall_fetch[t] = ent_vld && (ent_thread == THR_ID_W'(t)) && !leaving;
        end
    end

    // Issue bundle; held stable while the entry waits, zero when empty
    always_comb begin
        io.issue_valid = issue_fire;
        io.issue_info  = '0;
        if (ent_vld) begin
            io.issue_info.opcode       = opc;
            io.issue_info.cls          = cls;
            io.issue_info.thread       = ent_thread;
            io.issue_info.pc           = ent_pc;
            io.issue_info.rd           = rd;
            io.issue_info.rs1_val      = src_use[SRC_RS1] ? src_val[SRC_RS1] : '0;
            io.issue_info.rs2_val      = src_use[SRC_RS2] ? src_val[SRC_RS2] :
                                         src_use[SRC_RD]  ? src_val[SRC_RD]  : '0;
            io.issue_info.imm          = REG_WIDTH'($signed(ent_instr[IMM_HI:IMM_LO]));
            io.issue_info.xcpt         = ent_xcpt;
            io.issue_info.xcpt_illegal = (cls == CLS_ILL);
        end
    end

endmodule

// File: tb/tb_decode_issue_stage.sv
// Directed bench for decode_issue_stage with an expected-issue queue.
// Latency: expectations pushed at fetch drive, popped when issue_valid is seen.
// Backpressure: exercises hazards, alu_stall, flush and mid-stall reset.
module tb_decode_issue_stage;
    import decode_issue_stage_pkg::*;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    decode_issue_stage_if bus();

    decode_issue_stage dut (
        .clock (clock),
        .reset (reset),
        .io    (bus)
    );

    int total;
    int bad;
    decode_info_t exp_q[$];
    decode_info_t ei;
    fetch_xcpt_t  nox;
    fetch_xcpt_t  xaf;

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2,
                                       input logic [9:0] lo);
        return {op, rd, rs1, rs2, lo};
    endfunction

    function automatic decode_info_t exp_info(input logic [31:0] ins, input logic [31:0] pc,
                                              input logic thr, input fetch_xcpt_t x,
                                              input logic [31:0] v1, input logic [31:0] v2);
        decode_info_t d;
        logic [6:0] op;
        op = ins[31:25];
        d = '0;
        d.opcode = op;
        d.thread = thr;
        d.pc     = pc;
        d.rd     = ins[24:20];
        d.imm    = {{17{ins[14]}}, ins[14:0]};
        d.xcpt   = x;
        if (op < 7'h10)                     d.cls = CLS_ALU;
        else if (op == 7'h10 || op == 7'h11) d.cls = CLS_LD;
        else if (op == 7'h12 || op == 7'h13) d.cls = CLS_ST;
        else if (op == 7'h30 || op == 7'h31) d.cls = CLS_BR;
        else begin
            d.cls          = CLS_ILL;
            d.xcpt_illegal = 1'b1;
        end
        if (d.cls != CLS_ILL && x == '0) begin
            d.rs1_val = v1;
            d.rs2_val = v2;
        end
        return d;
    endfunction

    task automatic check_info(input string tag, input decode_info_t obs, input decode_info_t exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic check_iv(input string tag, input logic exp);
        total++;
        assert (bus.issue_valid === exp) else begin
            bad++;
            $error("FAIL %s: issue_valid got %b want %b", tag, bus.issue_valid, exp);
        end
    endtask

    task automatic check_st(input string tag, input logic [1:0] exp);
        total++;
        assert (bus.stall_fetch === exp) else begin
            bad++;
            $error("FAIL %s: stall_fetch got %b want %b", tag, bus.stall_fetch, exp);
        end
    endtask

    task automatic observe();
        decode_info_t e;
        if (bus.issue_valid === 1'b1) begin
            total++;
            assert (exp_q.size() != 0) else begin
                bad++;
                $error("FAIL spurious_issue: got %h want no issue", bus.issue_info);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_info("issue_info", bus.issue_info, e);
            end
        end
    endtask

    task automatic next();
        @(negedge clock);
    endtask

    task automatic settle();
        #1;
        observe();
    endtask

    task automatic fetch(input logic [31:0] ins, input logic [31:0] pc, input logic thr,
                         input fetch_xcpt_t x);
        bus.fetch_valid     = 1'b1;
        bus.fetch_instr     = ins;
        bus.fetch_pc        = pc;
        bus.fetch_thread_id = thr;
        bus.fetch_xcpt      = x;
    endtask

    task automatic idle();
        bus.fetch_valid = 1'b0;
        bus.fetch_instr = '0;
        bus.fetch_xcpt  = '0;
    endtask

    task automatic wb(input logic thr, input logic [4:0] r, input logic [31:0] data);
        bus.wb_valid     = 1'b1;
        bus.wb_thread_id = thr;
        bus.wb_reg       = r;
        bus.wb_data      = data;
    endtask

    task automatic wb_off();
        bus.wb_valid = 1'b0;
    endtask

    task automatic push(input logic [31:0] ins, input logic [31:0] pc, input logic thr,
                        input fetch_xcpt_t x, input logic [31:0] v1, input logic [31:0] v2);
        exp_q.push_back(exp_info(ins, pc, thr, x, v1, v2));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        nox   = '0;
        xaf   = '0;
        xaf.access_fault = 1'b1;
        reset = 1'b1;
        bus.fetch_valid = 1'b0; bus.fetch_instr = '0; bus.fetch_pc = '0;
        bus.fetch_thread_id = '0; bus.fetch_xcpt = '0; bus.flush = '0; bus.alu_stall = 1'b0;
        bus.wb_valid = 1'b0; bus.wb_thread_id = '0; bus.wb_reg = '0; bus.wb_data = '0;

        // Reset state
        next(); next(); next(); settle();
        check_iv("rst_issue_valid", 1'b0);
        check_st("rst_stall", 2'b00);
        check_info("rst_info", bus.issue_info, '0);

        // Preload r1=5, r2=7 on thread 0
        next(); reset = 1'b0; wb(1'b0, 5'd1, 32'd5); settle();
        next(); wb(1'b0, 5'd2, 32'd7); settle();
        next(); wb_off(); settle();

        // 1: ADD r3,r1,r2 issues one cycle after fetch
        next(); fetch(mk(7'h01, 5'd3, 5'd1, 5'd2, 10'h0), 32'h100, 1'b0, nox);
        push(mk(7'h01, 5'd3, 5'd1, 5'd2, 10'h0), 32'h100, 1'b0, nox, 32'd5, 32'd7); settle();
        check_iv("t1_same_cycle", 1'b0);
        next(); idle(); settle();
        check_iv("t1_issue", 1'b1);

        // 2: SUB r4,r3,r1 waits for r3, forwards wb data
        next(); fetch(mk(7'h02, 5'd4, 5'd3, 5'd1, 10'h0), 32'h104, 1'b0, nox);
        push(mk(7'h02, 5'd4, 5'd3, 5'd1, 10'h0), 32'h104, 1'b0, nox, 32'h10, 32'd5); settle();
        next(); idle(); settle();
        check_st("t2_stall_a", 2'b01); check_iv("t2_hold_a", 1'b0);
        next(); settle();
        check_st("t2_stall_b", 2'b01); check_iv("t2_hold_b", 1'b0);
        next(); wb(1'b0, 5'd3, 32'h10); settle();
        check_iv("t2_bypass_issue", 1'b1); check_st("t2_release", 2'b00);
        next(); wb_off(); settle();
        check_iv("t2_single", 1'b0);

        // 3: thread 1 waits behind thread 0's blocked entry without being stalled
        next(); fetch(mk(7'h01, 5'd3, 5'd1, 5'd2, 10'h0), 32'h108, 1'b0, nox);
        push(mk(7'h01, 5'd3, 5'd1, 5'd2, 10'h0), 32'h108, 1'b0, nox, 32'd5, 32'd7); settle();
        next(); fetch(mk(7'h02, 5'd5, 5'd3, 5'd2, 10'h0), 32'h10C, 1'b0, nox);
        push(mk(7'h02, 5'd5, 5'd3, 5'd2, 10'h0), 32'h10C, 1'b0, nox, 32'h22, 32'd7); settle();
        check_iv("t3_add", 1'b1);
        next(); fetch(mk(7'h01, 5'd6, 5'd1, 5'd2, 10'h0), 32'h200, 1'b1, nox);
        push(mk(7'h01, 5'd6, 5'd1, 5'd2, 10'h0), 32'h200, 1'b1, nox, 32'd0, 32'd0); settle();
        check_st("t3_thr1_free_a", 2'b01); check_iv("t3_block_a", 1'b0);
        next(); settle();
        check_st("t3_thr1_free_b", 2'b01); check_iv("t3_block_b", 1'b0);
        next(); wb(1'b0, 5'd3, 32'h22); settle();
        check_iv("t3_thr0_issue", 1'b1); check_st("t3_release", 2'b00);
        next(); wb_off(); idle(); settle();
        check_iv("t3_thr1_issue", 1'b1);

        // 4: flush drops the held entry and blocks same-cycle capture; r3 stays pending
        next(); fetch(mk(7'h01, 5'd3, 5'd1, 5'd2, 10'h0), 32'h110, 1'b0, nox);
        push(mk(7'h01, 5'd3, 5'd1, 5'd2, 10'h0), 32'h110, 1'b0, nox, 32'd5, 32'd7); settle();
        next(); fetch(mk(7'h02, 5'd7, 5'd3, 5'd1, 10'h0), 32'h114, 1'b0, nox); settle();
        check_iv("t4_add", 1'b1);
        next(); idle(); settle();
        check_st("t4_held", 2'b01);
        next(); bus.flush = 2'b01; fetch(mk(7'h01, 5'd8, 5'd1, 5'd2, 10'h0), 32'h118, 1'b0, nox); settle();
        check_iv("t4_flush_no_issue", 1'b0);
        next(); bus.flush = 2'b00; idle(); settle();
        check_iv("t4_dropped", 1'b0); check_st("t4_stall_clear", 2'b00);
        next(); fetch(mk(7'h02, 5'd7, 5'd3, 5'd1, 10'h0), 32'h11C, 1'b0, nox);
        push(mk(7'h02, 5'd7, 5'd3, 5'd1, 10'h0), 32'h11C, 1'b0, nox, 32'h33, 32'd5); settle();
        next(); idle(); settle();
        check_st("t4_sb_kept", 2'b01);
        next(); wb(1'b0, 5'd3, 32'h33); settle();
        check_iv("t4_issue", 1'b1);
        next(); wb_off(); settle();

        // 5: alu_stall for three cycles
        next(); fetch(mk(7'h03, 5'd9, 5'd1, 5'd2, 10'h0), 32'h120, 1'b0, nox);
        ei = exp_info(mk(7'h03, 5'd9, 5'd1, 5'd2, 10'h0), 32'h120, 1'b0, nox, 32'd5, 32'd7);
        exp_q.push_back(ei); settle();
        for (int k = 0; k < 3; k++) begin
            next(); idle(); bus.alu_stall = 1'b1; settle();
            check_iv("t5_stalled", 1'b0);
            check_st("t5_stall", 2'b01);
            check_info("t5_stable", bus.issue_info, ei);
        end
        next(); bus.alu_stall = 1'b0; settle();
        check_iv("t5_release", 1'b1);
        next(); settle();
        check_iv("t5_single", 1'b0);

        // 6: illegal opcode is a no-op that ignores pending sources and sets nothing
        next(); fetch(mk(7'h7F, 5'd10, 5'd9, 5'd4, 10'h0), 32'h124, 1'b0, nox);
        push(mk(7'h7F, 5'd10, 5'd9, 5'd4, 10'h0), 32'h124, 1'b0, nox, 32'd0, 32'd0); settle();
        next(); fetch(mk(7'h01, 5'd11, 5'd10, 5'd1, 10'h0), 32'h128, 1'b0, nox);
        push(mk(7'h01, 5'd11, 5'd10, 5'd1, 10'h0), 32'h128, 1'b0, nox, 32'd0, 32'd5); settle();
        check_iv("t6_illegal", 1'b1);
        next(); idle(); settle();
        check_iv("t6_no_sb_set", 1'b1);

        // Fetch exception: no hazard check, no reads, no scoreboard set
        next(); fetch(mk(7'h01, 5'd12, 5'd9, 5'd4, 10'h0), 32'h12C, 1'b0, xaf);
        push(mk(7'h01, 5'd12, 5'd9, 5'd4, 10'h0), 32'h12C, 1'b0, xaf, 32'd0, 32'd0); settle();
        next(); fetch(mk(7'h01, 5'd13, 5'd12, 5'd0, 10'h0), 32'h130, 1'b0, nox);
        push(mk(7'h01, 5'd13, 5'd12, 5'd0, 10'h0), 32'h130, 1'b0, nox, 32'd0, 32'd0); settle();
        check_iv("t6_xcpt", 1'b1);
        next(); idle(); settle();
        check_iv("t6_xcpt_no_sb", 1'b1);

        // r0: write-back ignored, never pending, never forwarded
        next(); wb(1'b0, 5'd0, 32'hDEAD); fetch(mk(7'h01, 5'd0, 5'd1, 5'd2, 10'h0), 32'h134, 1'b0, nox);
        push(mk(7'h01, 5'd0, 5'd1, 5'd2, 10'h0), 32'h134, 1'b0, nox, 32'd5, 32'd7); settle();
        next(); wb_off(); fetch(mk(7'h01, 5'd14, 5'd0, 5'd1, 10'h0), 32'h138, 1'b0, nox);
        push(mk(7'h01, 5'd14, 5'd0, 5'd1, 10'h0), 32'h138, 1'b0, nox, 32'd0, 32'd5); settle();
        check_iv("t6_wr_r0", 1'b1);
        next(); idle(); wb(1'b0, 5'd0, 32'hBEEF); settle();
        check_iv("t6_rd_r0", 1'b1); check_st("t6_r0_not_pending", 2'b00);

        // Store, branch and load decode, negative immediate
        next(); wb_off(); fetch(mk(7'h12, 5'd2, 5'd1, 5'd4, 10'h3FF), 32'h140, 1'b0, nox);
        push(mk(7'h12, 5'd2, 5'd1, 5'd4, 10'h3FF), 32'h140, 1'b0, nox, 32'd5, 32'd7); settle();
        next(); fetch(mk(7'h31, 5'd5, 5'd1, 5'd2, 10'h004), 32'h144, 1'b0, nox);
        push(mk(7'h31, 5'd5, 5'd1, 5'd2, 10'h004), 32'h144, 1'b0, nox, 32'd5, 32'd7); settle();
        check_iv("t6_st", 1'b1);
        next(); fetch(mk(7'h11, 5'd16, 5'd2, 5'h10, 10'h001), 32'h148, 1'b0, nox);
        push(mk(7'h11, 5'd16, 5'd2, 5'h10, 10'h001), 32'h148, 1'b0, nox, 32'd7, 32'd0); settle();
        check_iv("t6_br", 1'b1);
        next(); idle(); settle();
        check_iv("t6_ld", 1'b1);

        // Reset while stalled
        next(); fetch(mk(7'h02, 5'd17, 5'd16, 5'd1, 10'h0), 32'h14C, 1'b0, nox); settle();
        next(); idle(); settle();
        check_st("t6_pre_reset_stall", 2'b01);
        next(); reset = 1'b1; settle();
        next(); reset = 1'b0; settle();
        check_iv("t6_reset_valid", 1'b0);
        check_st("t6_reset_stall", 2'b00);
        check_info("t6_reset_info", bus.issue_info, '0);
        next(); fetch(mk(7'h01, 5'd18, 5'd1, 5'd16, 10'h0), 32'h150, 1'b0, nox);
        push(mk(7'h01, 5'd18, 5'd1, 5'd16, 10'h0), 32'h150, 1'b0, nox, 32'd0, 32'd0); settle();
        next(); idle(); settle();
        check_iv("t6_post_reset_issue", 1'b1);
        next(); settle();

        total++;
        assert (exp_q.size() == 0) else begin
            bad++;
            $error("FAIL queue_drained: got %0d left want 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
